uart_tx_queue: RTL

// - Byte queue between the CPU peripheral write path and the UART sender stage.
// - CPU writes bytes without polling; the block drains them one at a time into the sender.
// - Drain handshake: data + 1-cycle trigger pulse, then track the sender's busy flag through start and finish.
// - Exposes queue status (empty/full/level) for the peripheral status register.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_byte_fifo.sv | 79 +++++++
 rtl/uart_tx_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, transmit-queue FSM states and default queue depth.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } txq_state_t;

    localparam int UART_TXQ_DEFAULT_DEPTH = 16;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer with occupancy level and registered empty/full flags.
// A write to a full buffer is accepted only when a pop happens in the same cycle.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXQ_DEFAULT_DEPTH
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  uart_byte_t             wr_data,
    input  logic                   pop,
    output uart_byte_t             rd_data,
    output logic                   q_empty,
    output logic                   q_full,
    output logic [$clog2(DEPTH):0] q_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);

    uart_byte_t     mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic [LW-1:0]  level_nxt_s;
    logic           empty_r;
    logic           full_r;
    logic           push_s;

    // A pop in the same cycle frees the slot the incoming byte needs.
    assign push_s = wr_en && (!full_r || pop);

    // Next occupancy: push and pop together leave the level unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, level and status flags; flags are registered from the next level.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LVL_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            empty_r <= (level_nxt_s == LVL_ZERO);
            full_r  <= (level_nxt_s == LVL_FULL);
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sysclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign q_empty = empty_r;
    assign q_full  = full_r;
    assign q_level = level_r;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue between the CPU write path and the UART sender.
// Drains one byte at a time: present data, pulse tx_trigger, wait for tx_busy
// to rise (re-triggering after START_WAIT cycles) and then to fall.
// Optional feature macro: UART_TXQ_OVF_EN adds a sticky overflow flag.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH      = UART_TXQ_DEFAULT_DEPTH,
    parameter int START_WAIT = 8
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_trigger,
    output logic                   q_empty,
    output logic                   q_full,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   tx_idle
`ifdef UART_TXQ_OVF_EN
    ,output logic                  overflow
`endif
);

    localparam int CW = $clog2(START_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(START_WAIT - 1);

    txq_state_t     state_r;
    txq_state_t     state_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nxt_s;
    logic           pop_s;
    uart_byte_t     head_s;
    uart_byte_t     tx_data_r;
    logic           tx_trigger_r;
    logic           q_empty_s;
    logic           q_full_s;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .pop     (pop_s),
        .rd_data (head_s),
        .q_empty (q_empty_s),
        .q_full  (q_full_s),
        .q_level (q_level)
    );

    // Drain FSM next-state: only IDLE pops, so a byte is re-triggered until acknowledged.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!q_empty_s && !tx_busy) begin
                    pop_s       = 1'b1;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                cnt_nxt_s   = CW'(0);
                state_nxt_s = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = LOAD;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, start-wait counter, presented byte and trigger pulse (high exactly in LOAD).
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= CW'(0);
            tx_data_r    <= 8'h00;
            tx_trigger_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            tx_trigger_r <= (state_nxt_s == LOAD);
            if (pop_s) begin
                tx_data_r <= head_s;
            end
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_r;
    logic drop_s;

    assign drop_s = wr_en && q_full_s && !pop_s;

    // Sticky dropped-write flag; a write into an empty queue starts a fresh episode.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (wr_en && q_empty_s) begin
            ovf_r <= 1'b0;
        end
    end

    assign overflow = ovf_r;
`endif

    assign tx_data    = tx_data_r;
    assign tx_trigger = tx_trigger_r;
    assign q_empty    = q_empty_s;
    assign q_full     = q_full_s;
    assign tx_idle    = q_empty_s && (state_r == IDLE);

endmodule
